// File: rtl/deinterleave_pkg.sv
// Shared constants and helpers for the streaming block deinterleaver.
// Default geometry matches the existing 4-codeword x 15-bit frame format.
package deinterleave_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 15;
  localparam int ROW_W    = $clog2(DEF_ROWS);
  localparam int COL_W    = $clog2(DEF_COLS);

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  // Position of block element (r, c) in a frame flattened row-major.
  function automatic int frame_bit_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/dinter_bank.sv
// One frame buffer: ROWS x COLS bit array, written a column at a time and
// read a row at a time.
module dinter_bank
  import deinterleave_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  localparam int RW  = $clog2(ROWS),
  localparam int CW  = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [CW-1:0]   col,
  input  logic [ROWS-1:0] wdata,
  input  logic [RW-1:0]   row,
  output logic [COLS-1:0] rdata
);

  logic [COLS-1:0] mem_q [ROWS];

  // NOTE: the array is reset so out_data is defined (zero) from reset onward;
  // this is a small register array, not a RAM macro, so the reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) mem_q[r] <= '0;
    end else if (we) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      for (int r = 0; r < ROWS; r++) mem_q[r][col] <= wdata[r];
    end
  end

  assign rdata = mem_q[row];

endmodule

// File: rtl/stream_block_deinterleaver.sv
// Ping-pong block deinterleaver: one ROWS-bit column in per beat, one
// COLS-bit row (codeword) out per beat; one bank fills while the other drains.
module stream_block_deinterleaver
  import deinterleave_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  localparam int RW  = $clog2(ROWS),
  localparam int CW  = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic            in_ready,
  output logic [COLS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RW-1:0]   out_row,
  output logic            out_last,
  output logic            sync_err
);

  logic [1:0]    full_q, full_d;
  bank_e         wb_q, wb_d, rb_q, rb_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [RW-1:0] rrow_q, rrow_d;
  logic          sync_err_q, sync_err_d;

  logic          wr_fire, rd_fire, resync, wr_last, rd_last;
  logic [CW-1:0] wr_col;
  logic [1:0]    bank_we;
  logic [COLS-1:0] bank_rdata [2];

  assign in_ready = !full_q[wb_q];
  assign wr_fire  = in_valid && in_ready;
  // An in_sof beat mid-frame restarts the frame with itself as column 0.
  assign resync   = wr_fire && in_sof && (wcol_q != '0);
  assign wr_col   = resync ? '0 : wcol_q;
  assign wr_last  = wr_fire && !resync && (wcol_q == CW'(COLS - 1));

  assign rd_fire  = full_q[rb_q] && out_ready;
  assign rd_last  = rd_fire && (rrow_q == RW'(ROWS - 1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through this block can infer a latch.
    full_d     = full_q;
    wb_d       = wb_q;
    wcol_d     = wcol_q;
    rb_d       = rb_q;
    rrow_d     = rrow_q;
    sync_err_d = resync;

    if (wr_fire) begin
      if (resync) begin
        wcol_d = CW'(1);
      end else if (wr_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = (wb_q == BANK0) ? BANK1 : BANK0;
        wcol_d       = '0;
      end else begin
        wcol_d = wcol_q + CW'(1);
      end
    end

    // Write completion and read completion always target different banks.
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rb_q] = 1'b0;
        rb_d         = (rb_q == BANK0) ? BANK1 : BANK0;
        rrow_d       = '0;
      end else begin
        rrow_d = rrow_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wb_q       <= BANK0;
      wcol_q     <= '0;
      rb_q       <= BANK0;
      rrow_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wb_q       <= wb_d;
      wcol_q     <= wcol_d;
      rb_q       <= rb_d;
      rrow_q     <= rrow_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bank_we[0] = wr_fire && (wb_q == BANK0);
  assign bank_we[1] = wr_fire && (wb_q == BANK1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dinter_bank #(
      .ROWS (ROWS),
      .COLS (COLS)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[b]),
      .col   (wr_col),
      .wdata (in_data),
      .row   (rrow_q),
      .rdata (bank_rdata[b])
    );
  end

  assign out_valid = full_q[rb_q];
  assign out_data  = bank_rdata[rb_q];
  assign out_row   = rrow_q;
  assign out_last  = out_valid && (rrow_q == RW'(ROWS - 1));
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_stream_block_deinterleaver.sv
// Self-checking bench: directed table and sequences on the default 4x15 block,
// plus random streams on 8x16 and 2x7 instances, all scored against a frame model.
module tb_stream_block_deinterleaver;
  import deinterleave_pkg::*;

  localparam int R = 4;
  localparam int C = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default 4x15 instance
  logic [R-1:0] in_data;
  logic         in_valid, in_sof, in_ready;
  logic [C-1:0] out_data;
  logic         out_valid, out_ready, out_last, sync_err;
  logic [1:0]   out_row;

  // 8x16 instance
  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_sof, a_in_ready;
  logic [15:0] a_out_data;
  logic        a_out_valid, a_out_ready, a_out_last, a_sync_err;
  logic [2:0]  a_out_row;

  // 2x7 instance
  logic [1:0]  b_in_data;
  logic        b_in_valid, b_in_sof, b_in_ready;
  logic [6:0]  b_out_data;
  logic        b_out_valid, b_out_ready, b_out_last, b_sync_err;
  logic [0:0]  b_out_row;

  stream_block_deinterleaver dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last), .sync_err(sync_err));

  stream_block_deinterleaver #(.ROWS(8), .COLS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_sof(a_in_sof),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_row(a_out_row), .out_last(a_out_last), .sync_err(a_sync_err));

  stream_block_deinterleaver #(.ROWS(2), .COLS(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_sof(b_in_sof),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_row(b_out_row), .out_last(b_out_last), .sync_err(b_sync_err));

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row r of a frame given as the flat input stream: bit c = flat[c*rows + r].
  function automatic logic [15:0] exp_row(input logic [127:0] flat, input int rows,
                                          input int cols, input int r);
    logic [15:0] v = '0;
    for (int c = 0; c < cols; c++) v[c] = flat[frame_bit_idx(c, r, rows)];
    return v;
  endfunction

  // ---------------- reference model for the 4x15 instance ----------------
  logic [127:0] m_flat;
  logic [127:0] m_q[$];
  int m_wc = 0, m_rr = 0, m_rows = 0;
  logic m_err_exp = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wc = 0; m_rr = 0; m_err_exp = 1'b0; m_q.delete();
    end else begin
      check("in_ready", in_ready, m_q.size() < 2);
      check("out_valid", out_valid, m_q.size() != 0);
      check("sync_err", sync_err, m_err_exp);
      m_err_exp = 1'b0;
      if (out_valid && out_ready && m_q.size() != 0) begin
        check("out_data", out_data, exp_row(m_q[0], R, C, m_rr));
        check("out_row", out_row, m_rr);
        check("out_last", out_last, m_rr == R - 1);
        m_rows++;
        if (m_rr == R - 1) begin m_rr = 0; void'(m_q.pop_front()); end
        else m_rr++;
      end
      if (in_valid && in_ready) begin
        if (in_sof && m_wc != 0) begin m_wc = 0; m_err_exp = 1'b1; end
        m_flat[m_wc*R +: R] = in_data;
        m_wc++;
        if (m_wc == C) begin m_q.push_back(m_flat); m_wc = 0; end
      end
    end
  end

  // ---------------- reference model for the 8x16 instance ----------------
  logic [127:0] a_flat;
  logic [127:0] a_q[$];
  int a_wc = 0, a_rr = 0, a_rows = 0, a_frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_wc = 0; a_rr = 0; a_q.delete();
    end else begin
      check("a_in_ready", a_in_ready, a_q.size() < 2);
      check("a_out_valid", a_out_valid, a_q.size() != 0);
      check("a_sync_err", a_sync_err, 1'b0);
      if (a_out_valid && a_out_ready && a_q.size() != 0) begin
        check("a_out_data", a_out_data, exp_row(a_q[0], 8, 16, a_rr));
        check("a_out_row", a_out_row, a_rr);
        check("a_out_last", a_out_last, a_rr == 7);
        a_rows++;
        if (a_rr == 7) begin a_rr = 0; void'(a_q.pop_front()); end
        else a_rr++;
      end
      if (a_in_valid && a_in_ready) begin
        a_flat[a_wc*8 +: 8] = a_in_data;
        a_wc++;
        if (a_wc == 16) begin a_q.push_back(a_flat); a_frames++; a_wc = 0; end
      end
    end
  end

  // ---------------- reference model for the 2x7 instance ----------------
  logic [127:0] b_flat;
  logic [127:0] b_q[$];
  int b_wc = 0, b_rr = 0, b_rows = 0, b_frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_wc = 0; b_rr = 0; b_q.delete();
    end else begin
      check("b_in_ready", b_in_ready, b_q.size() < 2);
      check("b_out_valid", b_out_valid, b_q.size() != 0);
      check("b_sync_err", b_sync_err, 1'b0);
      if (b_out_valid && b_out_ready && b_q.size() != 0) begin
        check("b_out_data", b_out_data, exp_row(b_q[0], 2, 7, b_rr));
        check("b_out_row", b_out_row, b_rr);
        check("b_out_last", b_out_last, b_rr == 1);
        b_rows++;
        if (b_rr == 1) begin b_rr = 0; void'(b_q.pop_front()); end
        else b_rr++;
      end
      if (b_in_valid && b_in_ready) begin
        b_flat[b_wc*2 +: 2] = b_in_data;
        b_wc++;
        if (b_wc == 7) begin b_q.push_back(b_flat); b_frames++; b_wc = 0; end
      end
    end
  end

  // Present one column and hold it until accepted (bounded wait).
  task automatic send_col(input logic [R-1:0] d, input logic sof);
    int n = 0;
    in_data = d; in_sof = sof; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    check("send_timeout", n >= 200, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic [R-1:0] d;
    logic         rdy;
    logic         e_ir;
    logic         e_ov;
    logic [1:0]   e_row;
    logic         e_last;
    logic [C-1:0] e_data;
  } vec_t;

  vec_t tbl [C + 4];
  logic [127:0] flat1, fa;
  int r0;

  initial begin
    in_data = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_in_sof = 1'b0; a_out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b0;

    // reset state
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_row", out_row, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    #10 rst_n = 1'b1;
    step(1);

    // single frame, table driven: 15 columns then 4 drain cycles
    flat1 = '0;
    for (int c = 0; c < C; c++) begin
      logic [R-1:0] cv;
      cv = R'(c) ^ 4'hA;
      flat1[c*R +: R] = cv;
      tbl[c] = '{v: 1'b1, d: cv, rdy: 1'b1, e_ir: 1'b1, e_ov: (c == C - 1),
                 e_row: 2'd0, e_last: 1'b0, e_data: '0};
    end
    tbl[C-1].e_data = C'(exp_row(flat1, R, C, 0));
    for (int k = 0; k < 4; k++) begin
      tbl[C+k] = '{v: 1'b0, d: '0, rdy: 1'b1, e_ir: 1'b1, e_ov: (k < 3),
                   e_row: (k < 3) ? 2'(k + 1) : 2'd0, e_last: (k == 2),
                   e_data: (k < 3) ? C'(exp_row(flat1, R, C, k + 1)) : '0};
    end
    for (int i = 0; i < C + 4; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_sof = 1'b0; out_ready = tbl[i].rdy;
      step(1);
      check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_out_row", i), out_row, tbl[i].e_row);
      check($sformatf("tbl%0d_out_last", i), out_last, tbl[i].e_last);
      if (tbl[i].e_ov) check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
    end
    in_valid = 1'b0;

    // back-to-back three frames, no stalls expected
    out_ready = 1'b1; stalls = 0; r0 = m_rows;
    for (int i = 0; i < 3 * C; i++) send_col(R'($urandom), 1'b0);
    step(4);
    check("b2b_stalls", stalls, 0);
    check("b2b_rows", m_rows - r0, 12);
    check("b2b_drained", out_valid, 1'b0);

    // backpressure: two frames with out_ready low
    out_ready = 1'b0; fa = '0;
    for (int c = 0; c < C; c++) begin
      logic [R-1:0] d;
      d = R'($urandom);
      fa[c*R +: R] = d;
      send_col(d, 1'b0);
    end
    for (int c = 0; c < C; c++) send_col(R'($urandom), 1'b0);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_row", out_row, 2'd0);
    check("bp_out_data", out_data, exp_row(fa, R, C, 0));
    step(3);
    check("bp_frozen_data", out_data, exp_row(fa, R, C, 0));
    check("bp_frozen_row", out_row, 2'd0);
    out_ready = 1'b1;
    step(3);
    check("bp_row3", out_row, 2'd3);
    check("bp_last", out_last, 1'b1);
    check("bp_still_full", in_ready, 1'b0);
    step(1);
    check("bp_ready_back", in_ready, 1'b1);
    check("bp_second_bank", out_valid, 1'b1);
    check("bp_row_wrap", out_row, 2'd0);
    step(4);

    // resync mid-frame, then resync at the last column
    r0 = m_rows;
    for (int i = 0; i < 7; i++) send_col(R'($urandom), 1'b0);
    send_col(R'($urandom), 1'b1);
    check("rs_pulse", sync_err, 1'b1);
    step(1);
    check("rs_pulse_end", sync_err, 1'b0);
    for (int i = 0; i < C - 2; i++) send_col(R'($urandom), 1'b0);
    check("rs_no_early_frame", out_valid, 1'b0);
    send_col(R'($urandom), 1'b0);
    check("rs_frame_done", out_valid, 1'b1);
    for (int i = 0; i < C - 1; i++) send_col(R'($urandom), 1'b0);
    send_col(R'($urandom), 1'b1);
    check("rs_last_col_pulse", sync_err, 1'b1);
    for (int i = 0; i < C - 1; i++) send_col(R'($urandom), 1'b0);
    step(5);
    check("rs_rows", m_rows - r0, 8);

    // async reset mid-drain with the other bank full
    out_ready = 1'b0;
    for (int i = 0; i < 2 * C; i++) send_col(R'($urandom), 1'b0);
    out_ready = 1'b1;
    step(2);
    check("ar_row2", out_row, 2'd2);
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_out_data", out_data, '0);
    check("ar_out_row", out_row, '0);
    step(2);
    rst_n = 1'b1;
    step(1);
    r0 = m_rows;
    for (int i = 0; i < C; i++) send_col(R'($urandom), 1'b0);
    step(5);
    check("ar_fresh_rows", m_rows - r0, 4);
    check("ar_fresh_drained", out_valid, 1'b0);

    // random streams on the 8x16 and 2x7 instances
    fork
      begin
        repeat (3000) begin
          @(posedge clk); #1;
          a_in_valid  = ($urandom_range(0, 3) != 0);
          a_in_data   = 8'($urandom);
          a_out_ready = ($urandom_range(0, 3) != 0);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
      end
      begin
        repeat (3000) begin
          @(posedge clk); #1;
          b_in_valid  = ($urandom_range(0, 3) != 0);
          b_in_data   = 2'($urandom);
          b_out_ready = ($urandom_range(0, 3) != 0);
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
      end
    join
    step(40);
    check("a_rows_total", a_rows, a_frames * 8);
    check("a_drained", a_out_valid, 1'b0);
    check("b_rows_total", b_rows, b_frames * 2);
    check("b_drained", b_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
